// File: rtl/imm_gen_pipe.sv
// Registered immediate generator for the decode stage.
// Decodes I/S/B/U/J, CSR zimm and shift-amount immediates into an XLEN-wide value.
// The output register is backed by one skid entry, with valid/ready on both sides.
// A sideband tag rides with each immediate. A saturating counter tracks illegal
// format selects. XLEN must be 32 or 64.
module imm_gen_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5,
  parameter int unsigned ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      Instr,
  input  logic [2:0]       ImmSrc,
  input  logic [TAG_W-1:0] InTag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  ImmExt,
  output logic             ImmErr,
  output logic [TAG_W-1:0] OutTag,
  output logic [ERR_W-1:0] ErrCnt
);

  localparam bit Rv64 = (XLEN == 64);

  // Opcode bits never contribute to any immediate.
  logic unused_opcode;
  assign unused_opcode = ^Instr[6:0];

  logic [31:0]     v32;
  logic [5:0]      zx;
  logic            use_sx;
  logic [XLEN-1:0] dec_imm;
  logic            dec_err;

  logic             out_valid_q, out_valid_d;
  logic [XLEN-1:0]  out_imm_q, out_imm_d;
  logic             out_err_q, out_err_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic             skid_valid_q, skid_valid_d;
  logic [XLEN-1:0]  skid_imm_q, skid_imm_d;
  logic             skid_err_q, skid_err_d;
  logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  logic accept;
  logic drain;
  logic load_out;

  assign in_ready = !skid_valid_q;
  assign accept   = in_valid && in_ready;
  assign drain    = out_valid_q && out_ready;
  assign load_out = !out_valid_q || drain;

  // Format decode: sign-extending formats build a 32-bit value first, then widen.
  always_comb begin
    v32     = '0;
    zx      = '0;
    use_sx  = 1'b1;
    dec_err = 1'b0;
    unique case (ImmSrc)
      3'b000: v32 = {{20{Instr[31]}}, Instr[31:20]};
      3'b001: v32 = {{20{Instr[31]}}, Instr[31:25], Instr[11:7]};
      3'b010: v32 = {{19{Instr[31]}}, Instr[31], Instr[7], Instr[30:25], Instr[11:8], 1'b0};
      3'b011: v32 = {Instr[31:12], 12'b0};
      3'b100: v32 = {{11{Instr[31]}}, Instr[31], Instr[19:12], Instr[20], Instr[30:21], 1'b0};
      3'b101: begin
        use_sx = 1'b0;
        zx     = {1'b0, Instr[19:15]};
      end
      3'b110: begin
        // RV64 shifts take a 6-bit shamt, RV32 only 5.
        use_sx = 1'b0;
        zx     = {Rv64 & Instr[25], Instr[24:20]};
      end
      3'b111: begin
        use_sx  = 1'b0;
        dec_err = 1'b1;
      end
    endcase
    dec_imm = '0;
    if (use_sx) begin
      dec_imm       = {XLEN{v32[31]}};
      dec_imm[31:0] = v32;
    end else begin
      dec_imm[5:0] = zx;
    end
  end

  // Output register refills from skid first, else from a new accept; held output diverts to skid.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_imm_d    = out_imm_q;
    out_err_d    = out_err_q;
    out_tag_d    = out_tag_q;
    skid_valid_d = skid_valid_q;
    skid_imm_d   = skid_imm_q;
    skid_err_d   = skid_err_q;
    skid_tag_d   = skid_tag_q;
    if (load_out) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_imm_d    = skid_imm_q;
        out_err_d    = skid_err_q;
        out_tag_d    = skid_tag_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_valid_d = 1'b1;
        out_imm_d   = dec_imm;
        out_err_d   = dec_err;
        out_tag_d   = InTag;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_imm_d   = dec_imm;
      skid_err_d   = dec_err;
      skid_tag_d   = InTag;
    end
  end

  // Illegal-select counter saturates instead of wrapping.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (accept && dec_err && (err_cnt_q != {ERR_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  // State registers; reset discards both entries and clears the counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_imm_q    <= '0;
      out_err_q    <= 1'b0;
      out_tag_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      skid_err_q   <= 1'b0;
      skid_tag_q   <= '0;
      err_cnt_q    <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_imm_q    <= out_imm_d;
      out_err_q    <= out_err_d;
      out_tag_q    <= out_tag_d;
      skid_valid_q <= skid_valid_d;
      skid_imm_q   <= skid_imm_d;
      skid_err_q   <= skid_err_d;
      skid_tag_q   <= skid_tag_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign ImmExt    = out_imm_q;
  assign ImmErr    = out_err_q;
  assign OutTag    = out_tag_q;
  assign ErrCnt    = err_cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench: a 32-bit instance (2-bit error counter) and a 64-bit instance share stimulus.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] instr = '0;
  logic [2:0]  imm_src = '0;
  logic [4:0]  in_tag = '0;

  logic        a_in_ready, a_out_valid, a_err;
  logic [31:0] a_imm;
  logic [4:0]  a_tag;
  logic [1:0]  a_cnt;
  logic        b_in_ready, b_out_valid, b_err;
  logic [63:0] b_imm;
  logic [4:0]  b_tag;
  logic [7:0]  b_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(5), .ERR_W(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready), .Instr(instr),
    .ImmSrc(imm_src), .InTag(in_tag), .out_valid(a_out_valid), .out_ready(out_ready),
    .ImmExt(a_imm), .ImmErr(a_err), .OutTag(a_tag), .ErrCnt(a_cnt)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(5), .ERR_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready), .Instr(instr),
    .ImmSrc(imm_src), .InTag(in_tag), .out_valid(b_out_valid), .out_ready(out_ready),
    .ImmExt(b_imm), .ImmErr(b_err), .OutTag(b_tag), .ErrCnt(b_cnt)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    step;
    step;
    checks++;
    if ({a_out_valid, b_out_valid, a_in_ready, b_in_ready} !== 4'b0011) begin
      errors++;
      $display("FAIL reset_handshake: got ov=%b/%b ir=%b/%b expected ov=0/0 ir=1/1",
               a_out_valid, b_out_valid, a_in_ready, b_in_ready);
    end
    checks++;
    if (a_imm !== 32'h0 || b_imm !== 64'h0 || a_err !== 1'b0 || b_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_data: got imm=%h/%h err=%b/%b expected zeros", a_imm, b_imm,
               a_err, b_err);
    end
    checks++;
    if (a_tag !== 5'd0 || b_tag !== 5'd0 || a_cnt !== 2'd0 || b_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_tag_cnt: got tag=%0d/%0d cnt=%0d/%0d expected 0", a_tag, b_tag,
               a_cnt, b_cnt);
    end
    rst_n = 1'b1;
    step;
  endtask

  // Streams one word per cycle through every legal format; also exercises throughput.
  task automatic test_formats;
    logic [31:0] ins [0:10];
    logic [2:0]  src [0:10];
    logic [31:0] e32 [0:10];
    logic [63:0] e64 [0:10];
    ins = '{32'hFFF00093, 32'h00500093, 32'hFE112E23, 32'hFE000EE3, 32'h800000B7,
            32'h12345037, 32'h0010006F, 32'hFFFF8073, 32'hFFF00093, 32'h01F00013,
            32'h00112623};
    src = '{3'b000, 3'b000, 3'b001, 3'b010, 3'b011, 3'b011, 3'b100, 3'b101, 3'b110,
            3'b110, 3'b001};
    e32 = '{32'hFFFFFFFF, 32'h00000005, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h80000000,
            32'h12345000, 32'h00000800, 32'h0000001F, 32'h0000001F, 32'h0000001F,
            32'h0000000C};
    e64 = '{64'hFFFFFFFFFFFFFFFF, 64'h5, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFFC,
            64'hFFFFFFFF80000000, 64'h12345000, 64'h800, 64'h1F, 64'h3F, 64'h1F, 64'hC};
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      in_valid = 1'b1;
      instr    = ins[i];
      imm_src  = src[i];
      in_tag   = 5'(i);
      step;
      checks++;
      if ({a_out_valid, b_out_valid, a_in_ready, b_in_ready} !== 4'b1111) begin
        errors++;
        $display("FAIL fmt%0d_valid: got ov=%b/%b ir=%b/%b expected 1/1 1/1", i,
                 a_out_valid, b_out_valid, a_in_ready, b_in_ready);
      end
      checks++;
      if (a_imm !== e32[i]) begin
        errors++;
        $display("FAIL fmt%0d_imm32: got %h expected %h", i, a_imm, e32[i]);
      end
      checks++;
      if (b_imm !== e64[i]) begin
        errors++;
        $display("FAIL fmt%0d_imm64: got %h expected %h", i, b_imm, e64[i]);
      end
      checks++;
      if (a_err !== 1'b0 || b_err !== 1'b0 || a_tag !== 5'(i) || b_tag !== 5'(i)) begin
        errors++;
        $display("FAIL fmt%0d_err_tag: got err=%b/%b tag=%0d/%0d expected err=0 tag=%0d", i,
                 a_err, b_err, a_tag, b_tag, i);
      end
    end
    in_valid = 1'b0;
    step;
    checks++;
    if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL fmt_drain: got ov=%b/%b expected 0/0", a_out_valid, b_out_valid);
    end
  endtask

  // Five illegal selects: 2-bit counter saturates at 3, 8-bit counter keeps counting.
  task automatic test_illegal;
    logic [1:0] exp_a;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      instr    = 32'hFFFFFFFF;
      imm_src  = 3'b111;
      in_tag   = 5'(20 + i);
      exp_a    = (i >= 2) ? 2'd3 : 2'(i + 1);
      step;
      checks++;
      if (a_imm !== 32'h0 || b_imm !== 64'h0 || a_err !== 1'b1 || b_err !== 1'b1 ||
          a_out_valid !== 1'b1 || a_tag !== 5'(20 + i)) begin
        errors++;
        $display("FAIL ill%0d_out: got imm=%h/%h err=%b/%b ov=%b tag=%0d expected 0/0 1/1 1 %0d",
                 i, a_imm, b_imm, a_err, b_err, a_out_valid, a_tag, 20 + i);
      end
      checks++;
      if (a_cnt !== exp_a || b_cnt !== 8'(i + 1)) begin
        errors++;
        $display("FAIL ill%0d_cnt: got %0d/%0d expected %0d/%0d", i, a_cnt, b_cnt, exp_a,
                 i + 1);
      end
    end
    // Illegal select with in_valid low must not be counted or emitted.
    in_valid = 1'b0;
    step;
    step;
    checks++;
    if (a_cnt !== 2'd3 || b_cnt !== 8'd5 || a_out_valid !== 1'b0 || b_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_ignore: got cnt=%0d/%0d ov=%b/%b expected 3/5 0/0", a_cnt, b_cnt,
               a_out_valid, b_out_valid);
    end
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    instr     = 32'hFFF00093;
    imm_src   = 3'b000;
    in_tag    = 5'd1;
    step;
    checks++;
    if (a_out_valid !== 1'b1 || a_tag !== 5'd1 || a_in_ready !== 1'b1 ||
        a_imm !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL bp_first: got ov=%b tag=%0d ir=%b imm=%h expected 1 1 1 ffffffff",
               a_out_valid, a_tag, a_in_ready, a_imm);
    end
    instr   = 32'hFFFF8073;
    imm_src = 3'b101;
    in_tag  = 5'd2;
    step;
    checks++;
    if (a_in_ready !== 1'b0 || b_in_ready !== 1'b0 || a_tag !== 5'd1 ||
        a_imm !== 32'hFFFFFFFF || b_imm !== 64'hFFFFFFFFFFFFFFFF) begin
      errors++;
      $display("FAIL bp_skid: got ir=%b/%b tag=%0d imm=%h/%h expected 0/0 1 held", a_in_ready,
               b_in_ready, a_tag, a_imm, b_imm);
    end
    instr   = 32'h800000B7;
    imm_src = 3'b011;
    in_tag  = 5'd3;
    step;
    checks++;
    if (a_in_ready !== 1'b0 || a_tag !== 5'd1 || b_tag !== 5'd1 || a_out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_stall: got ir=%b tag=%0d/%0d ov=%b expected 0 1/1 1", a_in_ready,
               a_tag, b_tag, a_out_valid);
    end
    out_ready = 1'b1;
    step;
    checks++;
    if (a_tag !== 5'd2 || b_tag !== 5'd2 || a_imm !== 32'h1F || b_imm !== 64'h1F ||
        a_out_valid !== 1'b1 || a_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_tag2: got tag=%0d/%0d imm=%h/%h ov=%b ir=%b expected 2 1f 1 1", a_tag,
               b_tag, a_imm, b_imm, a_out_valid, a_in_ready);
    end
    step;
    checks++;
    if (a_tag !== 5'd3 || b_tag !== 5'd3 || a_imm !== 32'h80000000 ||
        b_imm !== 64'hFFFFFFFF80000000 || a_out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_tag3: got tag=%0d/%0d imm=%h/%h ov=%b expected 3 80000000", a_tag,
               b_tag, a_imm, b_imm, a_out_valid);
    end
    in_valid = 1'b0;
    step;
    checks++;
    if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_empty: got ov=%b/%b expected 0/0", a_out_valid, b_out_valid);
    end
  endtask

  task automatic test_reset_midop;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    instr     = 32'h0;
    imm_src   = 3'b111;
    in_tag    = 5'd7;
    step;
    instr   = 32'hFFF00093;
    imm_src = 3'b000;
    in_tag  = 5'd8;
    step;
    in_valid = 1'b0;
    checks++;
    if (a_in_ready !== 1'b0 || b_cnt !== 8'd6) begin
      errors++;
      $display("FAIL mid_full: got ir=%b cnt=%0d expected 0 6", a_in_ready, b_cnt);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0 || a_in_ready !== 1'b1 ||
        b_in_ready !== 1'b1 || a_cnt !== 2'd0 || b_cnt !== 8'd0) begin
      errors++;
      $display("FAIL mid_reset: got ov=%b/%b ir=%b/%b cnt=%0d/%0d expected 0/0 1/1 0/0",
               a_out_valid, b_out_valid, a_in_ready, b_in_ready, a_cnt, b_cnt);
    end
    checks++;
    if (a_imm !== 32'h0 || b_imm !== 64'h0 || a_tag !== 5'd0 || a_err !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_data: got imm=%h/%h tag=%0d err=%b expected zeros", a_imm,
               b_imm, a_tag, a_err);
    end
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    instr     = 32'h0010006F;
    imm_src   = 3'b100;
    in_tag    = 5'd9;
    step;
    in_valid = 1'b0;
    checks++;
    if (a_out_valid !== 1'b1 || a_tag !== 5'd9 || b_tag !== 5'd9 || a_imm !== 32'h800 ||
        b_imm !== 64'h800 || a_cnt !== 2'd0) begin
      errors++;
      $display("FAIL mid_after: got ov=%b tag=%0d/%0d imm=%h/%h cnt=%0d expected 1 9 800 0",
               a_out_valid, a_tag, b_tag, a_imm, b_imm, a_cnt);
    end
    step;
    checks++;
    if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_no_replay: got ov=%b/%b tag=%0d expected 0/0", a_out_valid,
               b_out_valid, a_tag);
    end
  endtask

  initial begin
    test_reset;
    test_formats;
    test_illegal;
    test_backpressure;
    test_reset_midop;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
